// File: rtl/neuron_pkg.sv
// neuron_pkg: default sizes and width helpers shared by the neuron datapath
package neuron_pkg;
  localparam int N_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int OUT_W_DEF = 2 * WIDTH_DEF + 2;
  function automatic int acc_w(input int n, input int width);
    return 2 * width + $clog2(n) + 1;
  endfunction
  function automatic int out_w(input int width);
    return 2 * width + 2;
  endfunction
endpackage

// File: rtl/neuron_mac.sv
// neuron_mac: signed WIDTH x WIDTH multiply with a registered, enable-held product
// ports: clk, rst (async active-high), en loads p, a/b signed operands, p 2*WIDTH-bit signed product
module neuron_mac import neuron_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);
  always_ff @(posedge clk or posedge rst)
    if (rst) p <= '0;
    else if (en) p <= a * b;
endmodule

// File: rtl/neuron.sv
// neuron: 2-stage pipelined dot product plus bias, activation and output saturation
// ports: clk, rst (async active-high), in_valid qualifies x/w/b, x/w N packed signed elements,
//        b signed bias, out_valid = in_valid delayed 2 cycles, y signed 2*WIDTH+2 result
// build option: NEURON_RELU_EN selects ReLU activation, otherwise linear
module neuron import neuron_pkg::*; #(
  parameter int N = N_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [N*WIDTH-1:0]              x,
  input  logic [N*WIDTH-1:0]              w,
  input  logic signed [WIDTH-1:0]         b,
  output logic                            out_valid,
  output logic signed [out_w(WIDTH)-1:0]  y
);
  localparam int ACC_W = acc_w(N, WIDTH);
  localparam int OUT_W = out_w(WIDTH);
  // comparison width wide enough for both the sum and the output limits
  localparam int SW = ACC_W > OUT_W ? ACC_W : OUT_W;
  localparam logic signed [SW-1:0] LO = $signed({1'b1, {(SW-1){1'b0}}}) >>> (SW - OUT_W);
  localparam logic signed [SW-1:0] HI = ~LO;
  logic signed [2*WIDTH-1:0] prod [N];
  logic signed [ACC_W-1:0] b1, sum;
  logic signed [SW-1:0] ext, act;
  logic v1;
  for (genvar i = 0; i < N; i++) begin : g_mac
    neuron_mac #(.WIDTH(WIDTH)) u_mac (
      .clk(clk),
      .rst(rst),
      .en(in_valid),
      .a(x[i*WIDTH +: WIDTH]),
      .b(w[i*WIDTH +: WIDTH]),
      .p(prod[i])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= 1'b0;
      b1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) b1 <= ACC_W'(b);
    end
  always_comb begin
    sum = b1;
    for (int i = 0; i < N; i++) sum = sum + ACC_W'(prod[i]);
    ext = SW'(sum);
`ifdef NEURON_RELU_EN
    act = ext < 0 ? '0 : ext;
`else
    act = ext;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      y <= '0;
    end else begin
      out_valid <= v1;
      if (v1) y <= act > HI ? HI[OUT_W-1:0] : act < LO ? LO[OUT_W-1:0] : act[OUT_W-1:0];
    end
endmodule

// File: tb/tb_neuron.sv
// tb_neuron: directed-vector self-checking bench for neuron (N=4, WIDTH=8)
module tb_neuron;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] w = '0;
  logic signed [7:0] b = '0;
  logic out_valid;
  logic signed [17:0] y;
  int vecs = 0;
  int errs = 0;
  neuron #(.N(4), .WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .x(x),
    .w(w),
    .b(b),
    .out_valid(out_valid),
    .y(y)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] pk(input int e3, input int e2, input int e1, input int e0);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction
  task automatic chk(input string tag, input logic [17:0] got, input int exp);
    logic [17:0] e;
    e = 18'(exp);
    vecs++;
    assert (got === e) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(got), $signed(e));
    end
  endtask
  task automatic drive(input logic [31:0] xv, input logic [31:0] wv, input int bv);
    @(negedge clk);
    in_valid = 1'b1;
    x = xv;
    w = wv;
    b = 8'(bv);
  endtask
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    x = '0;
    w = '0;
    b = '0;
  endtask
  task automatic single(input string tag, input logic [31:0] xv, input logic [31:0] wv, input int bv, input int exp);
    drive(xv, wv, bv);
    idle();
    chk({tag, "_early_valid"}, 18'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_valid"}, 18'(out_valid), 1);
    chk(tag, y, exp);
  endtask
  initial begin
    int neg9;
    int negbig;
`ifdef NEURON_RELU_EN
    neg9 = 0;
    negbig = 0;
`else
    neg9 = -9;
    negbig = -65152;
`endif
    #1;
    chk("reset_valid", 18'(out_valid), 0);
    chk("reset_y", y, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", 18'(out_valid), 0);
    single("zero", pk(0, 0, 0, 0), pk(0, 0, 0, 0), 0, 0);
    single("positive", pk(4, 3, 2, 1), pk(1, 1, 1, 1), 5, 15);
    @(negedge clk);
    chk("hold_valid", 18'(out_valid), 0);
    chk("hold_y", y, 15);
    single("negative", pk(2, 2, 2, 2), pk(-1, -1, -1, -1), -1, neg9);
    single("mixed_a", pk(5, -3, 2, 1), pk(2, 3, 4, 5), 3, 17);
    single("mixed_b", pk(5, -3, 2, 1), pk(2, 2, 2, 2), 3, 13);
    single("max", pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 127, 65663);
    single("min", pk(-128, -128, -128, -128), pk(127, 127, 127, 127), -128, negbig);
    drive(pk(4, 3, 2, 1), pk(1, 1, 1, 1), 5);
    drive(pk(5, -3, 2, 1), pk(2, 3, 4, 5), 3);
    idle();
    chk("b2b_first_valid", 18'(out_valid), 1);
    chk("b2b_first", y, 15);
    @(negedge clk);
    chk("b2b_second_valid", 18'(out_valid), 1);
    chk("b2b_second", y, 17);
    @(negedge clk);
    chk("b2b_after_valid", 18'(out_valid), 0);
    chk("b2b_after_y", y, 17);
    drive(pk(4, 3, 2, 1), pk(1, 1, 1, 1), 5);
    drive(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 127);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", 18'(out_valid), 0);
    chk("rst_y", y, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid_a", 18'(out_valid), 0);
    @(negedge clk);
    chk("post_rst_valid_b", 18'(out_valid), 0);
    chk("post_rst_y", y, 0);
    single("post_rst", pk(5, -3, 2, 1), pk(2, 2, 2, 2), 3, 13);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
